// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature generator: FSM state encoding and
// the mapping from the 2-bit phase counter onto the (a,b) output pair.
package quad_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Gray-coded (a,b) for each phase; up steps walk 00->01->11->10->00.
    localparam logic [1:0] PH0_AB = 2'b00;
    localparam logic [1:0] PH1_AB = 2'b01;
    localparam logic [1:0] PH2_AB = 2'b11;
    localparam logic [1:0] PH3_AB = 2'b10;

    function automatic logic [1:0] phase_to_ab(input logic [1:0] p);
        logic [1:0] ab;
        case (p)
            2'd0:    ab = PH0_AB;
            2'd1:    ab = PH1_AB;
            2'd2:    ab = PH2_AB;
            2'd3:    ab = PH3_AB;
            default: ab = PH0_AB;
        endcase
        return ab;
    endfunction

endpackage

// File: rtl/quad_gen_if.sv
// Command channel of the quadrature generator: valid/ready handshake with
// direction, step count and dwell, plus the abort request.
interface quad_gen_if #(
    parameter int WIDTH     = 8,
    parameter int DIV_WIDTH = 8
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_dir;
    logic [WIDTH-1:0]     cmd_steps;
    logic [DIV_WIDTH-1:0] cmd_dwell;
    logic                 abort;

    modport master (
        output cmd_valid, cmd_dir, cmd_steps, cmd_dwell, abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_steps, cmd_dwell, abort,
        output cmd_ready
    );
endinterface

// File: rtl/quad_tick.sv
// Dwell timer: loaded with D on command accept, then asserts o_tick on
// every D-th enabled clock so the first tick lands D clocks after the load.
module quad_tick #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_load,
    input  logic [DIV_WIDTH-1:0] i_dwell,
    input  logic                 i_en,
    output logic                 o_tick
);
    localparam logic [DIV_WIDTH-1:0] CNT_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    logic [DIV_WIDTH-1:0] r_d;
    logic [DIV_WIDTH-1:0] r_cnt;

    // Count down from D to 1, reloading D on the tick edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_d   <= {DIV_WIDTH{1'b0}};
            r_cnt <= {DIV_WIDTH{1'b0}};
        end else if (i_load) begin
            r_d   <= i_dwell;
            r_cnt <= i_dwell;
        end else if (i_en) begin
            if (r_cnt <= CNT_ONE) begin
                r_cnt <= r_d;
            end else begin
                r_cnt <= r_cnt - CNT_ONE;
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_tick = i_en && (r_cnt == CNT_ONE);

endmodule

// File: rtl/quad_gen.sv
// Quadrature step generator: accepts a (dir, steps, dwell) command and emits
// that many Gray-code transitions on a/b, one every D clocks, tracking the
// net position. An abort stops the command without a done pulse.
module quad_gen
    import quad_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV_WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    quad_gen_if.slave        cmd,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] position
);
    localparam logic [DIV_WIDTH-1:0] DWELL_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]     STEP_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_p;
    logic [1:0]           w_p_nxt;
    logic [1:0]           r_ab;
    logic [WIDTH-1:0]     r_pos;
    logic [WIDTH-1:0]     w_pos_nxt;
    logic [WIDTH-1:0]     r_left;
    logic [WIDTH-1:0]     w_left_nxt;
    logic                 r_dir;
    logic                 w_dir_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 w_accept;
    logic                 w_tick;
    logic [DIV_WIDTH-1:0] w_dwell;

    // A zero dwell behaves as one clock per transition.
    assign w_dwell  = (cmd.cmd_dwell == {DIV_WIDTH{1'b0}}) ? DWELL_ONE : cmd.cmd_dwell;
    assign w_accept = cmd.cmd_valid && (r_state == ST_IDLE);

    // Ready is gated by reset so it stays low for the whole reset window.
    assign cmd.cmd_ready = (r_state == ST_IDLE) && reset_n;

    quad_tick #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_accept),
        .i_dwell (w_dwell),
        .i_en    (r_state == ST_RUN),
        .o_tick  (w_tick)
    );

    // Next-state, step and done decode; abort outranks a coincident tick.
    always_comb begin
        w_state_nxt = r_state;
        w_p_nxt     = r_p;
        w_pos_nxt   = r_pos;
        w_left_nxt  = r_left;
        w_dir_nxt   = r_dir;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    w_dir_nxt  = cmd.cmd_dir;
                    w_left_nxt = cmd.cmd_steps;
                    if (cmd.cmd_steps == {WIDTH{1'b0}}) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cmd.abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tick) begin
                    if (r_dir) begin
                        w_p_nxt   = r_p + 2'd1;
                        w_pos_nxt = r_pos + STEP_ONE;
                    end else begin
                        w_p_nxt   = r_p - 2'd1;
                        w_pos_nxt = r_pos - STEP_ONE;
                    end
                    w_left_nxt = r_left - STEP_ONE;
                    if (r_left == STEP_ONE) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, phase, position and registered a/b/done outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_p     <= 2'd0;
            r_ab    <= 2'b00;
            r_pos   <= {WIDTH{1'b0}};
            r_left  <= {WIDTH{1'b0}};
            r_dir   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_p     <= w_p_nxt;
            r_ab    <= phase_to_ab(w_p_nxt);
            r_pos   <= w_pos_nxt;
            r_left  <= w_left_nxt;
            r_dir   <= w_dir_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign a        = r_ab[1];
    assign b        = r_ab[0];
    assign busy     = (r_state == ST_RUN);
    assign done     = r_done;
    assign position = r_pos;

endmodule

// File: tb/tb_quad_gen.sv
// Self-checking bench for quad_gen: a command table driven through a
// scoreboard (checked on each done pulse), a transition monitor, and
// hand-written abort / back-to-back / reset sequences.
module tb_quad_gen;
    localparam int WIDTH     = 8;
    localparam int DIV_WIDTH = 8;

    logic             clk     = 1'b0;
    logic             reset_n = 1'b0;
    logic             a;
    logic             b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] position;

    quad_gen_if #(.WIDTH(WIDTH), .DIV_WIDTH(DIV_WIDTH)) qif ();

    quad_gen #(.WIDTH(WIDTH), .DIV_WIDTH(DIV_WIDTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cmd      (qif),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .position (position)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] ab;
        logic [7:0] pos;
        int         lat;
    } exp_t;

    typedef struct {
        logic       rst;
        logic       dir;
        logic [7:0] steps;
        logic [7:0] dwell;
        logic [1:0] ab;
        logic [7:0] pos;
        int         lat;
    } vec_t;

    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    int         e0    = -1;
    int         cur_d = 1;
    logic [1:0] prev_ab = 2'b00;
    exp_t       sb_q[$];
    exp_t       mon_e;
    int         acc_q[$];
    vec_t       vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: single-bit transitions on the dwell grid, done vs scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            if ({a, b} !== prev_ab) begin
                chk("one_bit_change", $countones(prev_ab ^ {a, b}), 1);
                if (e0 >= 0) chk("dwell_grid", (cyc - e0) % cur_d, 0);
            end
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("ab_at_done", {a, b}, mon_e.ab);
                    chk("position_at_done", position, mon_e.pos);
                    chk("done_latency", cyc - e0, mon_e.lat);
                    chk("busy_at_done", busy, 0);
                    chk("ready_at_done", qif.cmd_ready, 1);
                end
            end
            if (qif.cmd_valid && qif.cmd_ready) begin
                e0    = cyc + 1;
                cur_d = (qif.cmd_dwell == 8'd0) ? 1 : int'(qif.cmd_dwell);
                acc_q.push_back(cyc + 1);
            end
        end
        prev_ab = {a, b};
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n       = 1'b0;
        qif.cmd_valid = 1'b0;
        qif.abort     = 1'b0;
        sb_q.delete();
        #1;
        chk("reset_outputs", {qif.cmd_ready, a, b, busy, done, position}, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", qif.cmd_ready, 1);
    endtask

    task automatic send(input logic dir, input logic [7:0] steps, input logic [7:0] dwell,
                        input logic [1:0] ab, input logic [7:0] pos, input int lat,
                        input logic with_abort);
        exp_t e;
        e.ab  = ab;
        e.pos = pos;
        e.lat = lat;
        @(posedge clk);
        #1;
        qif.cmd_valid = 1'b1;
        qif.cmd_dir   = dir;
        qif.cmd_steps = steps;
        qif.cmd_dwell = dwell;
        qif.abort     = with_abort;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        qif.cmd_valid = 1'b0;
        qif.abort     = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound && sb_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        qif.cmd_valid = 1'b0;
        qif.cmd_dir   = 1'b0;
        qif.cmd_steps = 8'd0;
        qif.cmd_dwell = 8'd0;
        qif.abort     = 1'b0;

        //           rst   dir   steps  dwell  ab     pos      lat
        vecs[0] = '{1'b1, 1'b1, 8'd4, 8'd3,  2'b00, 8'd4,   12};
        vecs[1] = '{1'b1, 1'b0, 8'd1, 8'd0,  2'b10, 8'd255, 1};
        vecs[2] = '{1'b0, 1'b1, 8'd0, 8'd5,  2'b10, 8'd255, 0};
        vecs[3] = '{1'b0, 1'b1, 8'd3, 8'd1,  2'b11, 8'd2,   3};
        vecs[4] = '{1'b0, 1'b0, 8'd5, 8'd2,  2'b01, 8'd253, 10};
        vecs[5] = '{1'b0, 1'b1, 8'd7, 8'd1,  2'b00, 8'd4,   7};
        vecs[6] = '{1'b0, 1'b0, 8'd6, 8'd4,  2'b11, 8'd254, 24};
        vecs[7] = '{1'b0, 1'b1, 8'd2, 8'd16, 2'b00, 8'd0,   32};

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].rst) do_reset();
            send(vecs[i].dir, vecs[i].steps, vecs[i].dwell,
                 vecs[i].ab, vecs[i].pos, vecs[i].lat, 1'b0);
            wait_drain(vecs[i].lat + 8);
            @(negedge clk);
            chk("idle_after_cmd", {busy, qif.cmd_ready}, 2'b01);
        end

        // Abort at E0+5 of up N=10 D=2: two transitions, no done.
        do_reset();
        @(posedge clk);
        #1;
        qif.cmd_valid = 1'b1; qif.cmd_dir = 1'b1; qif.cmd_steps = 8'd10; qif.cmd_dwell = 8'd2;
        @(posedge clk);
        #1;
        qif.cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        qif.abort = 1'b1;
        @(posedge clk);
        #1;
        qif.abort = 1'b0;
        @(negedge clk);
        chk("abort_position", position, 2);
        chk("abort_ab", {a, b}, 2'b11);
        chk("abort_ready", qif.cmd_ready, 1);
        chk("abort_busy", busy, 0);
        repeat (8) @(negedge clk);
        chk("abort_position_held", position, 2);

        // Abort on the edge of the only transition suppresses it.
        @(posedge clk);
        #1;
        qif.cmd_valid = 1'b1; qif.cmd_dir = 1'b1; qif.cmd_steps = 8'd1; qif.cmd_dwell = 8'd3;
        @(posedge clk);
        #1;
        qif.cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        qif.abort = 1'b1;
        @(posedge clk);
        #1;
        qif.abort = 1'b0;
        @(negedge clk);
        chk("abort_last_position", position, 2);
        chk("abort_last_ab", {a, b}, 2'b11);
        chk("abort_last_ready", qif.cmd_ready, 1);

        // Abort together with cmd_valid in IDLE still accepts.
        send(1'b1, 8'd1, 8'd1, 2'b10, 8'd3, 1, 1'b1);
        wait_drain(10);

        // Back-to-back accepts with cmd_valid held high.
        do_reset();
        acc_q.delete();
        begin
            exp_t e;
            e.lat = 2;
            e.ab = 2'b11; e.pos = 8'd2; sb_q.push_back(e);
            e.ab = 2'b00; e.pos = 8'd4; sb_q.push_back(e);
            e.ab = 2'b11; e.pos = 8'd6; sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        qif.cmd_valid = 1'b1; qif.cmd_dir = 1'b1; qif.cmd_steps = 8'd2; qif.cmd_dwell = 8'd1;
        repeat (7) @(posedge clk);
        #1;
        qif.cmd_valid = 1'b0;
        wait_drain(10);
        chk("b2b_accept_count", acc_q.size(), 3);
        if (acc_q.size() == 3) begin
            chk("b2b_gap_1", acc_q[1] - acc_q[0], 3);
            chk("b2b_gap_2", acc_q[2] - acc_q[1], 3);
        end

        // Reset mid-RUN abandons the command with no done pulse.
        @(posedge clk);
        #1;
        qif.cmd_valid = 1'b1; qif.cmd_dir = 1'b1; qif.cmd_steps = 8'd4; qif.cmd_dwell = 8'd1;
        @(posedge clk);
        #1;
        qif.cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrun_reset_outputs", {busy, done, a, b, position}, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_done_after_reset", {done, busy}, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/quad_gen.md
QUAD_GEN -- requirements
Module: quad_gen

Interface
REQ-001 Parameter WIDTH, default 8, width of step count and position.
REQ-002 Parameter DIV_WIDTH, default 8, width of step-dwell setting.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command can be accepted; high exactly when state is IDLE.
REQ-007 cmd_dir  input  1  1 = up (count increases at the receiving encoder), 0 = down.
REQ-008 cmd_steps  input  WIDTH  number of quadrature transitions to emit.
REQ-009 cmd_dwell  input  DIV_WIDTH  clocks between transitions; 0 treated as 1.
REQ-010 abort  input  1  stop the current command.
REQ-011 a  output  1  quadrature channel A, registered.
REQ-012 b  output  1  quadrature channel B, registered.
REQ-013 busy  output  1  high while state is RUN.
REQ-014 done  output  1  one-cycle pulse on normal completion.
REQ-015 position  output  WIDTH  net transitions emitted since reset, modulo 2^WIDTH.

Function
REQ-016 The block SHALL hold a 2-bit phase p; a = p[1], b = p[1]^p[0], giving the sequence (a,b) 00->01->11->10->00 for up steps.
REQ-017 An up step SHALL set p to p+1 mod 4 and position to position+1 mod 2^WIDTH; a down step SHALL set p to p-1 mod 4 and position to position-1 mod 2^WIDTH.
REQ-018 Each transition SHALL change exactly one of a, b.
REQ-019 States SHALL be IDLE and RUN only.
REQ-020 A command SHALL be accepted on an edge where cmd_valid && cmd_ready; cmd_dir, cmd_steps and D = max(cmd_dwell,1) SHALL be latched on that edge (E0).
REQ-021 Accept with cmd_steps = 0 SHALL stay in IDLE, emit no transition and pulse done in the cycle after E0.
REQ-022 Accept with cmd_steps = N > 0 SHALL enter RUN; the k-th transition (k = 1..N) SHALL occur at edge E0 + k*D.
REQ-023 On the edge of transition N the block SHALL return to IDLE, deassert busy and pulse done for exactly one cycle; earliest next accept is edge E0 + N*D + 1.
REQ-024 Inputs other than abort SHALL be ignored while in RUN.
REQ-025 abort high on any RUN edge SHALL return to IDLE on that edge with no transition on that edge, a/b/position held, and done not pulsed.
REQ-026 abort coinciding with the edge of a scheduled transition (including the last) SHALL suppress that transition.
REQ-027 abort in IDLE SHALL have no effect; abort and cmd_valid high together in IDLE SHALL still accept the command.
REQ-028 position wrap SHALL be silent (255 up -> 0, 0 down -> 255 for WIDTH = 8).

Reset
REQ-029 While reset_n is low: state IDLE, p = 0 (a = 0, b = 0), position = 0, busy = 0, done = 0, cmd_ready = 0 until reset_n is released, then 1.
REQ-030 reset_n assertion mid-RUN SHALL abandon the command immediately, without a done pulse.

Structure
REQ-031 Package quad_pkg SHALL hold the state encoding (IDLE, RUN) and the phase-to-(a,b) mapping constants.
REQ-032 The dwell counter SHALL be a sub-module quad_tick (load D, tick every D clocks while enabled); all other logic SHALL be in quad_gen.

Verification
REQ-033 Reset, then up, N = 4, dwell = 3: transitions at E0+3, +6, +9 and +12; (a,b) = 01, 11, 10, 00; position = 4; done high one cycle after E0+12.
REQ-034 Down, N = 1, dwell = 0 from reset: (a,b) = 10 at E0+1; position = 255; done pulse.
REQ-035 N = 0: no a/b change, busy never high, done one cycle after accept.
REQ-036 Up, N = 10, dwell = 2, abort at E0+5: exactly 2 transitions, position = 2, no done, cmd_ready high after the abort edge.
REQ-037 cmd_valid held high continuously with up, N = 2, dwell = 1: back-to-back accepts at E0, E0+3, E0+6; position increments by 2 per command.
REQ-038 Connect to the encoder/debounce chain with dwell >= 16: the encoder value matches position after each command (up and down, including wrap).
